memory_arbiter: RTL and testbench

Shares the CPU's single-port synchronous data/instruction memory between two requesters: port A (CPU fetch/load/store path, driven by the controller's memory sequencing) and port B (display/scan-out reader). Grants one access per cycle, issues it on the memory port, and returns read data to the owning requester one cycle later. Sits between the CPU datapath, the display block and the block RAM.

---
 rtl/memory_arbiter.sv | 76 +++++++
 tb/tb_memory_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous RAM between port A (CPU) and port B (display, fixed priority).
// Define MEMORY_ARBITER_STARVATION_GUARD_EN to force port A through after WAIT_LIMIT consecutive blocked cycles.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int WAIT_LIMIT    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     request_a,
    input  logic                     write_enable_a,
    input  logic [ADDRESS_WIDTH-1:0] address_a,
    input  logic [DATA_WIDTH-1:0]    write_data_a,
    input  logic                     request_b,
    input  logic                     write_enable_b,
    input  logic [ADDRESS_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0]    write_data_b,
    output logic                     grant_a,
    output logic                     grant_b,
    output logic                     read_valid_a,
    output logic                     read_valid_b,
    output logic [DATA_WIDTH-1:0]    read_data_a,
    output logic [DATA_WIDTH-1:0]    read_data_b,
    output logic [ADDRESS_WIDTH-1:0] memory_address,
    output logic                     memory_write_enable,
    output logic [DATA_WIDTH-1:0]    memory_write_data,
    input  logic [DATA_WIDTH-1:0]    memory_read_data
);
    logic force_a;
    logic pending_valid;
    logic pending_owner_b;

    if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_wait_limit
        $error("memory_arbiter: WAIT_LIMIT must be in 1..255");
    end

`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
    localparam int WAIT_WIDTH = $clog2(WAIT_LIMIT + 1);
    logic [WAIT_WIDTH-1:0] wait_count;
    assign force_a = request_a && (wait_count == WAIT_WIDTH'(WAIT_LIMIT));
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wait_count <= '0;
        else if (!request_a || grant_a)
            wait_count <= '0;
        else if (wait_count != WAIT_WIDTH'(WAIT_LIMIT))
            wait_count <= wait_count + WAIT_WIDTH'(1);
    end
`else
    assign force_a = 1'b0;
`endif

    // Grants are held low throughout reset so nothing reaches the RAM.
    always_comb begin
        grant_b             = !reset && request_b && !force_a;
        grant_a             = !reset && request_a && !grant_b;
        memory_address      = grant_b ? address_b : address_a;
        memory_write_data   = grant_b ? write_data_b : write_data_a;
        memory_write_enable = (grant_a && write_enable_a) || (grant_b && write_enable_b);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_valid   <= 1'b0;
            pending_owner_b <= 1'b0;
        end else begin
            pending_valid   <= (grant_a && !write_enable_a) || (grant_b && !write_enable_b);
            pending_owner_b <= grant_b;
        end
    end

    assign read_valid_a = pending_valid && !pending_owner_b;
    assign read_valid_b = pending_valid && pending_owner_b;
    assign read_data_a  = memory_read_data;
    assign read_data_b  = memory_read_data;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table vectors, directed corner sequences and randomized traffic checked against a
// transaction-level model (shadow memory plus one expected read return).
module tb_memory_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WL = 3;
`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ra = 0, wa = 0, rb = 0, wb = 0;
    logic [AW-1:0] aa = '0, ab = '0;
    logic [DW-1:0] da = '0, db = '0;
    logic grant_a, grant_b, read_valid_a, read_valid_b, memory_write_enable;
    logic [DW-1:0] read_data_a, read_data_b, memory_write_data, memory_read_data;
    logic [AW-1:0] memory_address;

    memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_LIMIT(WL)) dut (
        .clock(clock), .reset(reset),
        .request_a(ra), .write_enable_a(wa), .address_a(aa), .write_data_a(da),
        .request_b(rb), .write_enable_b(wb), .address_b(ab), .write_data_b(db),
        .grant_a(grant_a), .grant_b(grant_b),
        .read_valid_a(read_valid_a), .read_valid_b(read_valid_b),
        .read_data_a(read_data_a), .read_data_b(read_data_b),
        .memory_address(memory_address), .memory_write_enable(memory_write_enable),
        .memory_write_data(memory_write_data), .memory_read_data(memory_read_data)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] ram [256];
    always @(posedge clock) begin
        if (memory_write_enable) ram[memory_address[7:0]] <= memory_write_data;
        memory_read_data <= ram[memory_address[7:0]];
    end

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] shadow [256];
    bit pend = 0, pend_b = 0;
    logic [DW-1:0] pend_data = '0;
    int blocked = 0;
    bit last_ga = 0, last_gb = 0;
    logic s_ga, s_gb, s_mwe, s_rva, s_rvb;
    logic [AW-1:0] s_ma;
    logic [DW-1:0] s_rda, s_rdb;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 16) ? 16'hBEEF : 16'(i * 16'h0101) ^ 16'h5A00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit ra_, input bit wa_, input logic [AW-1:0] aa_, input logic [DW-1:0] da_,
                         input bit rb_, input bit wb_, input logic [AW-1:0] ab_, input logic [DW-1:0] db_);
        ra = ra_; wa = wa_; aa = aa_; da = da_;
        rb = rb_; wb = wb_; ab = ab_; db = db_;
    endtask

    // Called just after a rising edge: checks the cycle at the falling edge, then advances the model.
    task automatic tick();
        bit eb, ea;
        #4;
        eb = rb && !(GUARD && ra && blocked == WL);
        ea = ra && !eb;
        s_ga = grant_a; s_gb = grant_b; s_mwe = memory_write_enable; s_ma = memory_address;
        s_rva = read_valid_a; s_rvb = read_valid_b; s_rda = read_data_a; s_rdb = read_data_b;
        chk("grant_a", grant_a, ea);
        chk("grant_b", grant_b, eb);
        chk("mem_we", memory_write_enable, (ea && wa) || (eb && wb));
        chk("mem_addr", memory_address, eb ? ab : aa);
        chk("mem_wdata", memory_write_data, eb ? db : da);
        chk("read_valid_a", read_valid_a, pend && !pend_b);
        chk("read_valid_b", read_valid_b, pend && pend_b);
        if (pend) chk("read_data", pend_b ? read_data_b : read_data_a, pend_data);
        last_ga = ea; last_gb = eb;
        @(posedge clock);
        pend = (ea && !wa) || (eb && !wb);
        pend_b = eb;
        pend_data = eb ? shadow[ab[7:0]] : shadow[aa[7:0]];
        if (ea && wa) shadow[aa[7:0]] = da;
        if (eb && wb) shadow[ab[7:0]] = db;
        if (!ra || ea) blocked = 0;
        else if (blocked < WL) blocked++;
        #1;
    endtask

    typedef struct {
        bit ra, wa; logic [AW-1:0] aa; logic [DW-1:0] da;
        bit rb, wb; logic [AW-1:0] ab; logic [DW-1:0] db;
        bit ega, egb, emwe; logic [AW-1:0] ema;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vecs[9];
        int ga_count;
        logic [4:0] pattern;
        vecs[0] = '{0, 0, 16'h0033, 16'h0000, 0, 0, 16'h0044, 16'h0000, 0, 0, 0, 16'h0033};
        vecs[1] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0044, 16'h0000, 1, 0, 0, 16'h0010};
        vecs[2] = '{1, 1, 16'h0020, 16'hAAAA, 0, 0, 16'h0044, 16'h0000, 1, 0, 1, 16'h0020};
        vecs[3] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000, 0, 1, 0, 16'h0030};
        vecs[4] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0040, 16'hBBBB, 0, 1, 1, 16'h0040};
        vecs[5] = '{1, 1, 16'h0050, 16'h5555, 1, 0, 16'h0060, 16'h0000, 0, 1, 0, 16'h0060};
        vecs[6] = '{1, 1, 16'h0050, 16'h5555, 1, 1, 16'h0070, 16'h7777, 0, 1, 1, 16'h0070};
        vecs[7] = '{1, 1, 16'h0050, 16'h5555, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0050};
        vecs[8] = '{0, 0, 16'h00FF, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h00FF};

        @(posedge clock); #1;
        drive(1, 1, 16'h0001, 16'h1111, 1, 1, 16'h0002, 16'h2222);
        #1;
        chk("reset_grant_a", grant_a, 0);
        chk("reset_grant_b", grant_b, 0);
        chk("reset_mem_we", memory_write_enable, 0);
        chk("reset_read_valid", {read_valid_a, read_valid_b}, 0);
        @(posedge clock); #1;
        reset = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) begin
            drive(1, 1, 16'(i), init_word(i), 0, 0, 0, 0);
            tick();
        end

        foreach (vecs[i]) begin
            drive(vecs[i].ra, vecs[i].wa, vecs[i].aa, vecs[i].da, vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db);
            tick();
            chk("vec_grant_a", s_ga, vecs[i].ega);
            chk("vec_grant_b", s_gb, vecs[i].egb);
            chk("vec_mem_we", s_mwe, vecs[i].emwe);
            chk("vec_mem_addr", s_ma, vecs[i].ema);
        end

        drive(1, 0, 16'h0010, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("single_read_valid_a", s_rva, 1);
        chk("single_read_data_a", s_rda, 16'hBEEF);
        chk("single_read_valid_b", s_rvb, 0);

        drive(0, 0, 0, 0, 1, 1, 16'h0005, 16'h1234); tick();
        drive(0, 0, 0, 0, 1, 0, 16'h0005, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("wr_rd_b_valid", s_rvb, 1);
        chk("wr_rd_b_data", s_rdb, 16'h1234);

        drive(1, 0, 16'h0010, 0, 1, 0, 16'h0005, 0); tick();
        chk("contention_gb", {s_ga, s_gb}, 2'b01);
        drive(1, 0, 16'h0010, 0, 0, 0, 0, 0); tick();
        chk("contention_ga", {s_ga, s_gb}, 2'b10);
        chk("contention_rvb", s_rvb, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("contention_rva", s_rva, 1);
        chk("contention_rda", s_rda, 16'hBEEF);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 0, 16'(i), 0, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            if (i < 4) chk("b2b_grant_a", s_ga, 1);
            if (i > 0) begin
                chk("b2b_read_valid_a", s_rva, 1);
                chk("b2b_read_data_a", s_rda, init_word(i - 1));
            end
        end

        pattern = '0;
        ga_count = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 16'h0011, 0, 1, 0, 16'h0012, 0);
            tick();
            if (i < 5) pattern[i] = s_ga;
            ga_count += int'(s_ga);
        end
        if (GUARD) chk("guard_pattern", pattern, 5'b01000);
        else chk("starve_no_grant_a", ga_count, 0);
        drive(1, 0, 16'h0011, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("after_starve_rva", s_rva, 1);

        drive(1, 0, 16'h0010, 0, 0, 0, 0, 0); tick();
        reset = 1;
        drive(1, 0, 16'h0010, 0, 1, 0, 16'h0005, 0);
        #1;
        chk("rst_mid_read_valid_a", read_valid_a, 0);
        chk("rst_mid_grants", {grant_a, grant_b}, 0);
        chk("rst_mid_mem_we", memory_write_enable, 0);
        @(posedge clock); #1;
        chk("rst_hold_grants", {grant_a, grant_b}, 0);
        @(posedge clock); #1;
        reset = 0;
        pend = 0; blocked = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("rst_release_rva", s_rva, 0);
        drive(1, 0, 16'h0010, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("rst_resume_rva", s_rva, 1);
        chk("rst_resume_rda", s_rda, 16'hBEEF);

        last_ga = 0; last_gb = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!(ra && !last_ga)) begin
                ra = $urandom_range(0, 9) < 6; wa = $urandom_range(0, 2) == 0;
                aa = 16'($urandom_range(0, 255)); da = 16'($urandom);
            end
            if (!(rb && !last_gb)) begin
                rb = $urandom_range(0, 9) < 5; wb = $urandom_range(0, 2) == 0;
                ab = 16'($urandom_range(0, 255)); db = 16'($urandom);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
